// File: rtl/usr_shift_reg_pkg.sv
// Purpose : shared select encoding for the universal shift register.
// Contents: usr_mode_t (2-bit mode select) and the four mode constants.
package usr_pkg;

    typedef logic [1:0] usr_mode_t;

    localparam usr_mode_t SEL_HOLD = 2'd0;
    localparam usr_mode_t SEL_SHR  = 2'd1;
    localparam usr_mode_t SEL_SHL  = 2'd2;
    localparam usr_mode_t SEL_LOAD = 2'd3;

endpackage : usr_pkg

// File: rtl/usr_shift_reg_if.sv
// Purpose : control/data bundle of the universal shift register.
// Signals : select      - mode (hold / shift right / shift left / load)
//           p_din       - parallel load data
//           s_left_din  - serial input entering bit 0 on shift left
//           s_right_din - serial input entering bit WIDTH-1 on shift right
//           p_dout      - register contents
//           rotate      - only with USR_ROTATE_EN: shifts recirculate
// Modports: master drives the controls and reads p_dout; slave is the register.
interface usr_shift_reg_if #(
    parameter int unsigned WIDTH = 4
) ();
    import usr_pkg::*;

    usr_mode_t          select;
    logic [WIDTH-1:0]   p_din;
    logic               s_left_din;
    logic               s_right_din;
    logic [WIDTH-1:0]   p_dout;
`ifdef USR_ROTATE_EN
    logic               rotate;
`endif

    modport master (
`ifdef USR_ROTATE_EN
        output rotate,
`endif
        output select,
        output p_din,
        output s_left_din,
        output s_right_din,
        input  p_dout
    );

    modport slave (
`ifdef USR_ROTATE_EN
        input  rotate,
`endif
        input  select,
        input  p_din,
        input  s_left_din,
        input  s_right_din,
        output p_dout
    );

endinterface : usr_shift_reg_if

// File: rtl/usr_shift_reg_bit_cell.sv
// Purpose : one storage bit of the universal shift register: a flop fed by a
//           4:1 mux of itself, its two neighbours and its parallel-load bit.
// Ports   : clk, rst (sync, active-high), sel (mode), left_nbr (next more
//           significant bit, used on shift right), right_nbr (next less
//           significant bit, used on shift left), par_in (load bit), q.
module usr_bit_cell
    import usr_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  usr_mode_t sel,
    input  logic      left_nbr,
    input  logic      right_nbr,
    input  logic      par_in,
    output logic      q
);

    logic q_q;
    logic q_d;

    // Mode mux
    always_comb begin
        q_d = q_q;
        case (sel)
            SEL_HOLD: q_d = q_q;
            SEL_SHR:  q_d = left_nbr;
            SEL_SHL:  q_d = right_nbr;
            SEL_LOAD: q_d = par_in;
            default:  q_d = q_q;
        endcase
    end

    // Storage flop, reset wins over every mode
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : usr_bit_cell

// File: rtl/usr_shift_reg.sv
// Purpose : WIDTH-bit universal shift register (hold, shift right, shift
//           left, parallel load), one operation per rising clk edge.
// Ports   : clk, rst (synchronous, active-high), bus (usr_shift_reg_if.slave).
// Option  : USR_ROTATE_EN adds bus.rotate; with it set, shifts recirculate the
//           bit falling off one end instead of taking the serial input.
module usr_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    usr_shift_reg_if.slave  bus
);

    logic [WIDTH-1:0] q;
    logic             msb_src;
    logic             lsb_src;

    // Sources for the two end cells: serial inputs, or the opposite end on rotate
    always_comb begin
        msb_src = bus.s_right_din;
        lsb_src = bus.s_left_din;
`ifdef USR_ROTATE_EN
        if (bus.rotate) begin
            msb_src = q[0];
            lsb_src = q[WIDTH-1];
        end
`endif
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        logic left_nbr;
        logic right_nbr;

        if (i == int'(WIDTH) - 1) begin : g_msb
            assign left_nbr = msb_src;
        end else begin : g_hi
            assign left_nbr = q[i+1];
        end

        if (i == 0) begin : g_lsb
            assign right_nbr = lsb_src;
        end else begin : g_lo
            assign right_nbr = q[i-1];
        end

        usr_bit_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .sel       (bus.select),
            .left_nbr  (left_nbr),
            .right_nbr (right_nbr),
            .par_in    (bus.p_din[i]),
            .q         (q[i])
        );
    end

    assign bus.p_dout = q;

endmodule : usr_shift_reg

// File: tb/tb_usr_shift_reg.sv
// Purpose : self-checking bench for usr_shift_reg (WIDTH=4). An arithmetic
//           model is compared against p_dout every cycle after the first
//           reset; directed steps also carry hand-computed literal values.
module tb_usr_shift_reg;
    import usr_pkg::*;

    localparam int unsigned WIDTH = 4;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    usr_shift_reg_if #(.WIDTH(WIDTH)) bus ();

    usr_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: integer arithmetic on the register value
    logic [WIDTH-1:0] model;
    bit               model_valid;
    int               m;
    int               mask;
    bit               rot;

    initial begin
        model_valid = 1'b0;
        model       = '0;
    end

    always @(posedge clk) begin
        mask = (1 << WIDTH) - 1;
        m    = int'(model);
        rot  = 1'b0;
`ifdef USR_ROTATE_EN
        rot  = bus.rotate;
`endif
        if (rst) begin
            m           = 0;
            model_valid = 1'b1;
        end else if (bus.select == 2'd1) begin
            if (rot) m = (m >> 1) | ((m & 1) << (WIDTH - 1));
            else     m = (m >> 1) | (int'(bus.s_right_din) << (WIDTH - 1));
        end else if (bus.select == 2'd2) begin
            if (rot) m = ((m << 1) & mask) | ((m >> (WIDTH - 1)) & 1);
            else     m = ((m << 1) & mask) | int'(bus.s_left_din);
        end else if (bus.select == 2'd3) begin
            m = int'(bus.p_din);
        end
        model = WIDTH'(m);
    end

    // Per-cycle compare, on the falling edge away from the active edge
    always @(negedge clk) begin
        if (model_valid) begin
            n_total++;
            if (bus.p_dout === model) n_pass++;
            else $display("FAIL model_cmp t=%0t: p_dout=%b expected=%b", $time, bus.p_dout, model);
        end
    end

    task automatic step(input logic r, input logic [1:0] sel, input logic [WIDTH-1:0] din,
                        input logic sl, input logic sr, input logic ro);
        @(negedge clk);
        rst             = r;
        bus.select      = sel;
        bus.p_din       = din;
        bus.s_left_din  = sl;
        bus.s_right_din = sr;
`ifdef USR_ROTATE_EN
        bus.rotate      = ro;
`else
        if (ro) $display("note: rotate ignored in this build");
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] exp);
        n_total++;
        if (bus.p_dout === exp) n_pass++;
        else $display("FAIL %s: p_dout=%b expected=%b", name, bus.p_dout, exp);
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        rst             = 1'b0;
        bus.select      = SEL_HOLD;
        bus.p_din       = '0;
        bus.s_left_din  = 1'b0;
        bus.s_right_din = 1'b0;
`ifdef USR_ROTATE_EN
        bus.rotate      = 1'b0;
`endif

        // Reset beats a load
        step(1'b1, 2'd3, 4'b1101, 1'b0, 1'b0, 1'b0); check("reset", 4'b0000);

        // Load, then repeated load keeps the value
        step(1'b0, 2'd3, 4'b1101, 1'b0, 1'b0, 1'b0); check("load",   4'b1101);
        step(1'b0, 2'd3, 4'b1101, 1'b1, 1'b1, 1'b0); check("reload", 4'b1101);

        // Shift right
        step(1'b0, 2'd1, 4'b0000, 1'b1, 1'b0, 1'b0); check("shr0_a", 4'b0110);
        step(1'b0, 2'd1, 4'b1111, 1'b1, 1'b0, 1'b0); check("shr0_b", 4'b0011);
        step(1'b0, 2'd1, 4'b0000, 1'b0, 1'b1, 1'b0); check("shr1",   4'b1001);

        // Shift left
        step(1'b0, 2'd3, 4'b1101, 1'b0, 1'b0, 1'b0); check("load2",  4'b1101);
        step(1'b0, 2'd2, 4'b0000, 1'b1, 1'b0, 1'b0); check("shl1_a", 4'b1011);
        step(1'b0, 2'd2, 4'b0000, 1'b1, 1'b1, 1'b0); check("shl1_b", 4'b0111);

        // Hold with all other inputs toggling
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 2'd0, 4'((i * 5) + 3), 1'(i), 1'(i + 1), 1'(i)); check("hold", 4'b0111);
        end

        // Mid-stream reset, then shift out of zero
        step(1'b0, 2'd1, 4'b0000, 1'b0, 1'b1, 1'b0); check("shr_pre_rst", 4'b1011);
        step(1'b1, 2'd1, 4'b1111, 1'b1, 1'b1, 1'b0); check("mid_reset",   4'b0000);
        step(1'b0, 2'd2, 4'b1111, 1'b1, 1'b0, 1'b0); check("post_reset",  4'b0001);
        // s_right_din must not leak into a left shift
        step(1'b0, 2'd2, 4'b1111, 1'b0, 1'b1, 1'b0); check("shl_ignore_sr", 4'b0010);
        // s_left_din must not leak into a right shift
        step(1'b0, 2'd1, 4'b0000, 1'b1, 1'b0, 1'b0); check("shr_ignore_sl", 4'b0001);

`ifdef USR_ROTATE_EN
        step(1'b0, 2'd3, 4'b1101, 1'b0, 1'b0, 1'b0); check("rot_load", 4'b1101);
        step(1'b0, 2'd1, 4'b0000, 1'b0, 1'b0, 1'b1); check("rot_right", 4'b1110);
        step(1'b0, 2'd2, 4'b0000, 1'b0, 1'b0, 1'b1); check("rot_left",  4'b1101);
        step(1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 1'b1); check("rot_hold",  4'b1101);
        step(1'b0, 2'd3, 4'b0110, 1'b1, 1'b1, 1'b1); check("rot_load2", 4'b0110);
`endif

        // Mixed traffic checked against the model only
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_usr_shift_reg

// File: doc/usr_shift_reg.md
Name: usr_shift_reg

Overview:
- WIDTH-bit universal shift register: hold, shift right, shift left, parallel load, chosen each clock by a 2-bit mode select.
- Generic storage/serialisation primitive for datapath and serial-interface logic.
- Single clock domain; all state updates on rising edge of clk.

Parameters:
- WIDTH, 4, register width in bits (legal range >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- select  input  2  mode: 0 hold, 1 shift right, 2 shift left, 3 parallel load.
- p_din  input  WIDTH  parallel load data.
- s_left_din  input  1  serial input for shift-left; enters bit 0 (LSB).
- s_right_din  input  1  serial input for shift-right; enters bit WIDTH-1 (MSB).
- p_dout  output  WIDTH  register contents (direct flop outputs, no combinational path from inputs).

Behaviour:
- Reset is synchronous and active-high: on a rising clk edge with rst=1, p_dout <= 0. rst has priority over select.
- rst deasserted mid-stream: first edge with rst=0 applies the select mode to the all-zero state.
- Per rising edge, rst=0:
  - select=0 (hold): p_dout unchanged.
  - select=1 (shift right): p_dout <= {s_right_din, p_dout[WIDTH-1:1]}; old bit 0 discarded.
  - select=2 (shift left): p_dout <= {p_dout[WIDTH-2:0], s_left_din}; old bit WIDTH-1 discarded.
  - select=3 (load): p_dout <= p_din.
- Latency: one clock. p_dout reflects the operation after the edge where select/data were sampled.
- Serial inputs are sampled only in their own shift mode and ignored otherwise. p_din is sampled only in load mode.
- No handshake; an operation occurs every cycle.
- select is fully decoded; no illegal codes.
- Power-up value before the first reset edge is undefined (X in simulation).

Optional Feature:
- Macro USR_ROTATE_EN.
- Defined:
  - Extra input port rotate (1 bit).
  - rotate=1 with select=1: p_dout <= {p_dout[0], p_dout[WIDTH-1:1]}.
  - rotate=1 with select=2: p_dout <= {p_dout[WIDTH-2:0], p_dout[WIDTH-1]}.
  - In both cases serial inputs are ignored.
  - rotate has no effect in hold or load modes.
- Undefined: no rotate port; behaviour exactly as above.

Decomposition:
- Package usr_pkg: select encoding constants SEL_HOLD=2'd0, SEL_SHR=2'd1, SEL_SHL=2'd2, SEL_LOAD=2'd3, plus a 2-bit mode typedef.
- One sub-module, usr_bit_cell:
  - Contains one flop plus a 4:1 mux (inputs: self, left neighbour, right neighbour, parallel bit) with synchronous reset.
  - Top level instantiates WIDTH cells via generate and wires neighbours and serial inputs at the ends.

Test Plan:
- Reset: rst=1 for 1 edge with select=3, p_din=4'b1101 -> p_dout=4'b0000 (reset wins).
- Load: rst=0, select=3, p_din=4'b1101 -> p_dout=4'b1101 after one edge; holds value under repeated loads.
- Shift right: from 4'b1101, select=1, s_right_din=0 for 2 edges -> 4'b0110 then 4'b0011. With s_right_din=1, from 4'b0011 -> 4'b1001.
- Shift left: from 4'b1101, select=2, s_left_din=1 for 2 edges -> 4'b1011 then 4'b0111.
- Hold: select=0 for 5 edges with p_din, s_left_din and s_right_din toggling -> p_dout constant.
- Mid-operation reset: during shifting, assert rst for one edge -> 4'b0000. Next edge with select=2, s_left_din=1 -> 4'b0001. (USR_ROTATE_EN build: from 4'b1101, rotate=1, select=1 -> 4'b1110.)
